seq_sub_80b_16: RTL and testbench

SEQ_SUB_80B_16 -- requirements
Module: seq_sub_80b_16

---
 rtl/seq_sub_80b_16.sv | 125 ++++++++++++
 tb/tb_seq_sub_80b_16.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_sub_80b_16.sv
// Sequential 80-bit subtractor: D = A - B - Bin, computed one 16-bit slice per cycle.
// Optional signed-overflow output ovf is built when OVF_FLAG_EN is defined.
module seq_sub_80b_16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [79:0] A,
   input  logic [79:0] B,
   input  logic        Bin,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [79:0] D,
   output logic        Bout
`ifdef OVF_FLAG_EN
   ,
   output logic        ovf
`endif
);

   localparam int unsigned W  = 80;
   localparam int unsigned SW = 16;
   localparam int unsigned NS = W / SW;
   localparam int unsigned IW = 3;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t         state;
   state_t         state_nxt;
   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic           borrow;
   logic [IW-1:0]  idx;

   logic           load_c;
   logic           step_c;
   logic           last_c;

   logic [6:0]     shamt;
   logic [W-1:0]   a_sh;
   logic [W-1:0]   b_sh;
   logic [SW:0]    sl_res;
   logic [W-1:0]   slice_val;
   logic [W-1:0]   slice_mask;

   // State register; handshake outputs are registered alongside the state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         in_ready  <= (state_nxt == IDLE);
         out_valid <= (state_nxt == DONE);
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = RUN;
         RUN:     if (idx == IW'(NS - 1)) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Control decode
   always_comb begin
      load_c = 1'b0;
      step_c = 1'b0;
      last_c = 1'b0;
      case (state)
         IDLE:    load_c = in_valid;
         RUN: begin
            step_c = 1'b1;
            last_c = (idx == IW'(NS - 1));
         end
         default: ;
      endcase
   end

   // Current slice subtraction; the slice position is a shift by idx*16
   always_comb begin
      shamt      = {idx, 4'b0000};
      a_sh       = a_q >> shamt;
      b_sh       = b_q >> shamt;
      sl_res     = (SW+1)'(a_sh[SW-1:0]) - (SW+1)'(b_sh[SW-1:0]) - (SW+1)'(borrow);
      slice_val  = W'(sl_res[SW-1:0]) << shamt;
      slice_mask = W'({SW{1'b1}}) << shamt;
   end

   // Operand capture and slice-by-slice datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         borrow <= 1'b0;
         idx    <= '0;
         D      <= '0;
         Bout   <= 1'b0;
`ifdef OVF_FLAG_EN
         ovf    <= 1'b0;
`endif
      end else if (load_c) begin
         a_q    <= A;
         b_q    <= B;
         borrow <= Bin;
         idx    <= '0;
      end else if (step_c) begin
         D      <= (D & ~slice_mask) | slice_val;
         borrow <= sl_res[SW];
         idx    <= idx + IW'(1);
         if (last_c) begin
            Bout <= sl_res[SW];
`ifdef OVF_FLAG_EN
            ovf  <= (a_q[W-1] != b_q[W-1]) && (sl_res[SW-1] != a_q[W-1]);
`endif
         end
      end
   end

endmodule

// File: tb/tb_seq_sub_80b_16.sv
// Testbench for seq_sub_80b_16: vector table, scoreboard queue, latency/hold/reset sequences.
// Define OVF_FLAG_EN for both bench and RTL to exercise the ovf output.
module tb_seq_sub_80b_16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [79:0] A;
   logic [79:0] B;
   logic        Bin;
   logic        out_valid;
   logic        out_ready;
   logic [79:0] D;
   logic        Bout;
   logic        ovf_w;

   seq_sub_80b_16 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .Bin       (Bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .D         (D),
      .Bout      (Bout)
`ifdef OVF_FLAG_EN
      ,
      .ovf       (ovf_w)
`endif
   );

`ifndef OVF_FLAG_EN
   assign ovf_w = 1'b0;
`endif

   always #5 clk = ~clk;

   typedef struct {
      logic [79:0] a;
      logic [79:0] b;
      logic        bin;
      logic [79:0] d;
      logic        bout;
      logic        ovf;
      int          hold;
   } vec_t;

   typedef struct {
      logic [79:0] d;
      logic        bout;
      logic        ovf;
   } exp_t;

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Reference model at full width, independent of slicing
   function automatic exp_t model(input logic [79:0] a, input logic [79:0] b, input logic bin);
      exp_t e;
      logic [80:0] r;
      r      = {1'b0, a} - {1'b0, b} - 81'(bin);
      e.d    = r[79:0];
      e.bout = r[80];
      e.ovf  = (a[79] != b[79]) && (r[79] != a[79]);
      return e;
   endfunction

   function automatic logic [79:0] rnd80();
      return 80'({$urandom(), $urandom(), $urandom()});
   endfunction

   // Drive one operation, check latency, hold-stability and handshake; compare at transfer
   task automatic run_op(input logic [79:0] a, input logic [79:0] b, input logic bin,
                         input exp_t e, input int hold);
      int   lat;
      exp_t got;
      out_ready = 1'b0;
      check("in_ready_idle", 80'(in_ready), 80'(1));
      A = a; B = b; Bin = bin; in_valid = 1'b1;
      @(posedge clk); #1;
      sb.push_back(e);
      A = rnd80(); B = rnd80(); Bin = ~bin;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      in_valid = 1'b0;
      check("latency", 80'(lat), 80'(5));
      check("in_ready_busy", 80'(in_ready), 80'(0));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("hold_valid", 80'(out_valid), 80'(1));
         check("hold_d", D, e.d);
         check("hold_in_ready", 80'(in_ready), 80'(0));
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      if (sb.size() == 0) begin
         check("sb_empty", 80'(0), 80'(1));
      end else begin
         got = sb.pop_front();
         check("d", D, got.d);
         check("bout", 80'(Bout), 80'(got.bout));
`ifdef OVF_FLAG_EN
         check("ovf", 80'(ovf_w), 80'(got.ovf));
`endif
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("post_valid", 80'(out_valid), 80'(0));
      check("post_in_ready", 80'(in_ready), 80'(1));
   endtask

   vec_t vecs[$];
   vec_t v;
   exp_t e;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      A = '0; B = '0; Bin = 1'b0;
      #12;
      check("rst_in_ready", 80'(in_ready), 80'(1));
      check("rst_out_valid", 80'(out_valid), 80'(0));
      check("rst_d", D, 80'h0);
      check("rst_bout", 80'(Bout), 80'(0));
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      vecs.push_back('{80'h1, 80'h1, 1'b0, 80'h0, 1'b0, 1'b0, 0});
      vecs.push_back('{80'h0, 80'h0, 1'b1, 80'hFFFFFFFFFFFFFFFFFFFF, 1'b1, 1'b0, 1});
      vecs.push_back('{80'hABCDEF1234567890FFFF, 80'h11111111111111111111, 1'b1,
                       80'h9ABCDE012345677FEEED, 1'b0, 1'b0, 0});
      vecs.push_back('{80'h00000000000000010000, 80'h1, 1'b0,
                       80'h0000000000000000FFFF, 1'b0, 1'b0, 4});
      vecs.push_back('{80'h80000000000000000000, 80'h1, 1'b0,
                       80'h7FFFFFFFFFFFFFFFFFFF, 1'b0, 1'b1, 0});
      vecs.push_back('{80'h7FFFFFFFFFFFFFFFFFFF, 80'hFFFFFFFFFFFFFFFFFFFF, 1'b0,
                       80'h80000000000000000000, 1'b1, 1'b1, 2});
      for (int i = 0; i < 4; i++) begin
         v.a = rnd80(); v.b = rnd80(); v.bin = 1'($urandom_range(1));
         e = model(v.a, v.b, v.bin);
         v.d = e.d; v.bout = e.bout; v.ovf = e.ovf; v.hold = $urandom_range(2);
         vecs.push_back(v);
      end

      foreach (vecs[i]) begin
         e.d = vecs[i].d; e.bout = vecs[i].bout; e.ovf = vecs[i].ovf;
         run_op(vecs[i].a, vecs[i].b, vecs[i].bin, e, vecs[i].hold);
      end

      // Reset two cycles into RUN abandons the operation
      A = 80'h123456789; B = 80'h5; Bin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_in_ready", 80'(in_ready), 80'(1));
      check("arst_out_valid", 80'(out_valid), 80'(0));
      check("arst_d", D, 80'h0);
      check("arst_bout", 80'(Bout), 80'(0));
`ifdef OVF_FLAG_EN
      check("arst_ovf", 80'(ovf_w), 80'(0));
`endif
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         check("arst_no_valid", 80'(out_valid), 80'(0));
      end

      e = model(80'hFEDCBA9876543210ABCD, 80'h0123456789ABCDEF0123, 1'b1);
      run_op(80'hFEDCBA9876543210ABCD, 80'h0123456789ABCDEF0123, 1'b1, e, 1);

      check("sb_drained", 80'(sb.size()), 80'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
